// File: rtl/router_pkg.sv
// router_pkg
// Shared constants and types for the 1x3 router datapath.
//   ROUTER_WIDTH / FIFO_DEPTH : default byte width and per-port buffer depth
//   HDR_*                     : bit positions of the header fields
//                               (payload length in [7:2], destination in [1:0])
//   fifo_word_t               : one buffer entry, header flag plus payload byte
//   hdr_byte_count()          : bytes that follow a header (payload + parity)
package router_pkg;

    localparam int ROUTER_WIDTH = 8;
    localparam int FIFO_DEPTH   = 16;

    localparam int HDR_LEN_MSB  = 7;
    localparam int HDR_LEN_LSB  = 2;
    localparam int HDR_ADDR_MSB = 1;
    localparam int HDR_ADDR_LSB = 0;

    localparam int CNT_W = HDR_LEN_MSB - HDR_LEN_LSB + 2;

    typedef struct packed {
        logic                    lfd;
        logic [ROUTER_WIDTH-1:0] data;
    } fifo_word_t;

    // Header length field counts payload bytes; the parity byte adds one more.
    function automatic logic [CNT_W-1:0] hdr_byte_count(input logic [ROUTER_WIDTH-1:0] hdr);
        return CNT_W'(hdr[HDR_LEN_MSB:HDR_LEN_LSB]) + CNT_W'(1);
    endfunction

endpackage

// File: rtl/router_fifo_ram.sv
// router_fifo_ram
// Simple dual-port register array: synchronous write, asynchronous read.
//   clock   : write clock
//   wr_en   : write strobe for wr_addr
//   wr_addr : write address
//   wr_data : word to store
//   rd_addr : read address (combinational lookup)
//   rd_data : word currently stored at rd_addr
module router_fifo_ram #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 9
) (
    input  logic                     clock,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [DATA_W-1:0]        rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the array has no reset; an entry is only ever read after it has
    // been written, so clearing it would buy nothing and blocks RAM mapping.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/router_fifo.sv
// router_fifo
// Per-port output buffer of the 1x3 router. Stores {lfd, byte} words from the
// input stage and tracks packet boundaries so data_out returns to 0 once the
// last byte of a packet has been read and the buffer is empty.
//   clock      : single clock, rising edge
//   reset      : asynchronous active-high clear of all state
//   soft_reset : synchronous flush; wins over read and write in the same cycle
//   write_enb  : write strobe (ignored while full)
//   read_enb   : read strobe (ignored while empty)
//   lfd_state  : data_in is a packet header
//   data_in    : byte to store
//   data_out   : registered read data
//   full       : no free entry
//   empty      : no stored entry
// WIDTH must equal ROUTER_WIDTH: header decoding is byte based.
module router_fifo
    import router_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,
    parameter int WIDTH = ROUTER_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             soft_reset,
    input  logic             write_enb,
    input  logic             read_enb,
    input  logic             lfd_state,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [CNT_W-1:0] byte_cnt;
    fifo_word_t       wr_word;
    fifo_word_t       rd_word;
    logic             do_write;
    logic             do_read;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    assign do_write = write_enb && !full  && !soft_reset;
    assign do_read  = read_enb  && !empty && !soft_reset;

    assign wr_word = '{lfd: lfd_state, data: data_in};

    router_fifo_ram #(
        .DEPTH  (DEPTH),
        .DATA_W ($bits(fifo_word_t))
    ) u_ram (
        .clock   (clock),
        .wr_en   (do_write),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data (wr_word),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (rd_word)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement or process order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (soft_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_write) wr_ptr <= wr_ptr + 1'b1;
            if (do_read)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // A header read loads the remaining byte count; later reads count it down.
    // Once the count is exhausted and nothing is left, the output returns to 0.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            byte_cnt <= '0;
            data_out <= '0;
        end else if (soft_reset) begin
            byte_cnt <= '0;
            data_out <= '0;
        end else if (do_read) begin
            data_out <= rd_word.data;
            if (rd_word.lfd) begin
                byte_cnt <= hdr_byte_count(rd_word.data);
            end else if (byte_cnt != '0) begin
                byte_cnt <= byte_cnt - 1'b1;
            end
        end else if (byte_cnt == '0 && empty) begin
            data_out <= '0;
        end
    end

endmodule
